// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write master for the register file.
// Selects ALU or extended load data, blocks r0 writes, flags misaligned loads, counts retirements.
module writeback_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mvalid,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mdestReg,
  input  logic [31:0]      mr,
  input  logic [31:0]      mdo,
  input  logic [2:0]       mload_type,
  input  logic             mflush,
  output logic             wwreg,
  output logic [4:0]       wdestReg,
  output logic [31:0]      wbData,
  output logic             wvalid,
  output logic             misalign_err,
  output logic [4:0]       err_dest,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] LdB  = 3'd1;
  localparam logic [2:0] LdBu = 3'd2;
  localparam logic [2:0] LdH  = 3'd3;
  localparam logic [2:0] LdHu = 3'd4;

  logic             cap;
  logic             mis;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  logic             wwreg_d, wwreg_q;
  logic [4:0]       wdest_d, wdest_q;
  logic [31:0]      wbdata_d, wbdata_q;
  logic             wvalid_d, wvalid_q;
  logic             err_d, err_q;
  logic [4:0]       err_dest_d, err_dest_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign cap = mvalid & ~mflush;

  always_comb begin
    byte_sel = mdo[7:0];
    case (mr[1:0])
      2'd0: byte_sel = mdo[7:0];
      2'd1: byte_sel = mdo[15:8];
      2'd2: byte_sel = mdo[23:16];
      2'd3: byte_sel = mdo[31:24];
      default: byte_sel = mdo[7:0];
    endcase
    half_sel = mr[1] ? mdo[31:16] : mdo[15:0];

    load_data = mdo;
    mis       = (mr[1:0] != 2'd0);
    case (mload_type)
      LdB: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        mis       = 1'b0;
      end
      LdBu: begin
        load_data = {24'd0, byte_sel};
        mis       = 1'b0;
      end
      LdH: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        mis       = mr[0];
      end
      LdHu: begin
        load_data = {16'd0, half_sel};
        mis       = mr[0];
      end
      default: begin
        load_data = mdo;
        mis       = (mr[1:0] != 2'd0);
      end
    endcase
  end

  always_comb begin
    wwreg_d    = cap & mwreg & (mdestReg != 5'd0) & ~(mm2reg & mis);
    wdest_d    = mdestReg;
    wbdata_d   = mm2reg ? load_data : mr;
    wvalid_d   = cap;
    err_d      = err_q;
    err_dest_d = err_dest_q;
    // Only the first misaligned load records its destination.
    if (cap && mwreg && mm2reg && mis && !err_q) begin
      err_d      = 1'b1;
      err_dest_d = mdestReg;
    end
    cnt_d = wvalid_q ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wwreg_q    <= 1'b0;
      wdest_q    <= 5'd0;
      wbdata_q   <= 32'd0;
      wvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      err_dest_q <= 5'd0;
      cnt_q      <= '0;
    end else begin
      wwreg_q    <= wwreg_d;
      wdest_q    <= wdest_d;
      wbdata_q   <= wbdata_d;
      wvalid_q   <= wvalid_d;
      err_q      <= err_d;
      err_dest_q <= err_dest_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wwreg        = wwreg_q;
  assign wdestReg     = wdest_q;
  assign wbData       = wbdata_q;
  assign wvalid       = wvalid_q;
  assign misalign_err = err_q;
  assign err_dest     = err_dest_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage with a behavioural register file on the falling edge.
module tb_writeback_stage;

  typedef struct packed {
    logic        wwreg;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        wvalid;
    logic        err;
    logic [4:0]  edst;
    logic [31:0] cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mvalid, mwreg, mm2reg, mflush;
  logic [4:0]  mdestReg;
  logic [31:0] mr, mdo;
  logic [2:0]  mload_type;
  logic        wwreg, wvalid, misalign_err;
  logic [4:0]  wdestReg, err_dest;
  logic [31:0] wbData, retire_count;

  int n_cmp = 0;
  int n_bad = 0;

  out_t sb[$];
  logic        m_wvalid, m_err;
  logic [4:0]  m_edst;
  logic [31:0] m_cnt;
  logic [31:0] rf[32];

  writeback_stage #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
    .mdestReg(mdestReg), .mr(mr), .mdo(mdo), .mload_type(mload_type), .mflush(mflush),
    .wwreg(wwreg), .wdestReg(wdestReg), .wbData(wbData), .wvalid(wvalid),
    .misalign_err(misalign_err), .err_dest(err_dest), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wwreg) rf[wdestReg] <= wbData;

  function automatic out_t observed();
    return '{wwreg, wdestReg, wbData, wvalid, misalign_err, err_dest, retire_count};
  endfunction

  task automatic model_reset();
    m_wvalid = 1'b0;
    m_err    = 1'b0;
    m_edst   = 5'd0;
    m_cnt    = 32'd0;
    sb.delete();
  endtask

  // Drive one memory-stage instruction, queue its expected WB outputs, advance one edge.
  task automatic step(input logic v, input logic wr, input logic m2r, input logic [4:0] d,
                      input logic [31:0] r, input logic [31:0] dw, input logic [2:0] lt,
                      input logic fl);
    out_t        e;
    logic        cap, mis;
    logic [31:0] sh8, sh16, ld;
    mvalid = v; mwreg = wr; mm2reg = m2r; mdestReg = d; mr = r; mdo = dw;
    mload_type = lt; mflush = fl;
    cap  = v && !fl;
    sh8  = dw >> (8 * r[1:0]);
    sh16 = dw >> (16 * r[1]);
    if (lt == 3'd1)      begin ld = {{24{sh8[7]}}, sh8[7:0]};    mis = 1'b0; end
    else if (lt == 3'd2) begin ld = {24'd0, sh8[7:0]};           mis = 1'b0; end
    else if (lt == 3'd3) begin ld = {{16{sh16[15]}}, sh16[15:0]}; mis = r[0]; end
    else if (lt == 3'd4) begin ld = {16'd0, sh16[15:0]};         mis = r[0]; end
    else                 begin ld = dw;                          mis = (r[1:0] != 2'd0); end
    if (m_wvalid) m_cnt = m_cnt + 1;
    m_wvalid = cap;
    if (cap && wr && m2r && mis && !m_err) begin
      m_err  = 1'b1;
      m_edst = d;
    end
    e.wwreg  = cap && wr && (d != 5'd0) && !(m2r && mis);
    e.dest   = d;
    e.data   = m2r ? ld : r;
    e.wvalid = cap;
    e.err    = m_err;
    e.edst   = m_edst;
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    out_t o;
    o = observed();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", o, out_t'('0));
    end
  endtask

  task automatic test_alu_write();
    out_t o, e;
    step(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'd0, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL alu_write[%0d]: got %h expected %h", i, o, e);
      end
      if (i == 0) bubble();
    end
    n_cmp++;
    if (rf[5] !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL alu_rf_commit: got %h expected %h", rf[5], 32'h1234_5678);
    end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  lt[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] adr[4] = '{32'h2002, 32'h2003, 32'h2002, 32'h2000};
    logic [31:0] ref_v[4] = '{32'hFFFF_FFF1, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F01};
    out_t o, e;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 5'(10 + i), adr[i], 32'h80F1_7F01, lt[i], 1'b0);
      e = sb.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e || wbData !== ref_v[i]) begin
        n_bad++;
        $display("FAIL subword_load[%0d]: got %h expected %h (data %h)", i, o, e, ref_v[i]);
      end
    end
  endtask

  task automatic test_r0_protect();
    out_t o, e;
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 3'd0, 1'b0);
    bubble();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      if (i == 1) begin
        o = observed();
        n_cmp++;
        if (o.wwreg !== e.wwreg || o.wvalid !== e.wvalid || o.cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL r0_protect: got %h expected %h", o, e);
        end
      end
    end
    n_cmp++;
    if (rf[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL r0_rf: got %h expected %h", rf[0], 32'd0);
    end
  endtask

  task automatic test_misalign();
    out_t o, e;
    step(1'b1, 1'b1, 1'b1, 5'd7, 32'h1002, 32'h5555_AAAA, 3'd0, 1'b0);
    e = sb.pop_front();
    o = observed();
    n_cmp++;
    if (o !== e || !misalign_err || err_dest !== 5'd7) begin
      n_bad++;
      $display("FAIL misalign_lw: got %h expected %h", o, e);
    end
    step(1'b1, 1'b1, 1'b1, 5'd9, 32'h1001, 32'h5555_AAAA, 3'd3, 1'b0);
    e = sb.pop_front();
    o = observed();
    n_cmp++;
    if (o !== e || err_dest !== 5'd7) begin
      n_bad++;
      $display("FAIL misalign_lh_sticky: got %h expected %h", o, e);
    end
  endtask

  task automatic test_flush_bubble();
    out_t o, e;
    step(1'b1, 1'b1, 1'b1, 5'd12, 32'h3003, 32'h1111_2222, 3'd0, 1'b1);
    bubble();
    bubble();
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      o = observed();
      if (i == 2) begin
        n_cmp++;
        // dest/data are don't-care on a bubble
        if (!e.wvalid) begin o.dest = e.dest; o.data = e.data; end
        if (o !== e) begin
          n_bad++;
          $display("FAIL flush_bubble: got %h expected %h", o, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    out_t o, e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd3, vals[i], 32'd0, 3'd0, 1'b0);
      e = sb.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e);
      end
    end
    bubble();
    void'(sb.pop_front());
    n_cmp++;
    if (rf[3] !== 32'hCCCC_0003) begin
      n_bad++;
      $display("FAIL back_to_back_rf: got %h expected %h", rf[3], 32'hCCCC_0003);
    end
  endtask

  task automatic test_async_reset();
    out_t o, e;
    logic [31:0] old;
    old = rf[20];
    step(1'b1, 1'b1, 1'b0, 5'd20, 32'hCAFE_BABE, 32'd0, 3'd0, 1'b0);
    e = sb.pop_front();
    o = observed();
    n_cmp++;
    if (o !== e || !wwreg) begin
      n_bad++;
      $display("FAIL async_pre: got %h expected %h", o, e);
    end
    #1 resetn = 1'b0;
    #1;
    o = observed();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL async_reset_state: got %h expected %h", o, out_t'('0));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rf[20] !== old) begin
      n_bad++;
      $display("FAIL async_rf_untouched: got %h expected %h", rf[20], old);
    end
    model_reset();
    resetn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 5'd21, 32'h0000_0042, 32'd0, 3'd0, 1'b0);
    e = sb.pop_front();
    o = observed();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL post_reset_capture: got %h expected %h", o, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    resetn = 1'b0;
    mvalid = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mflush = 1'b0;
    mdestReg = 5'd0; mr = 32'd0; mdo = 32'd0; mload_type = 3'd0;
    model_reset();
    #1;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    test_alu_write();
    test_subword_loads();
    test_r0_protect();
    test_misalign();
    test_flush_bubble();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the pipelined MIPS core, acting as the write master for the register file. Each cycle it captures the memory-stage result into the MEM/WB pipeline register. It selects ALU or load data and sign- or zero-extends sub-word loads. It then drives the register file's write port (write enable, destination, data), which the register file commits on the falling edge of the same cycle. It also blocks writes to register 0, flags misaligned loads and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports (clock and reset first):
- clk  input  1  core clock; pipeline register updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- mvalid  input  1  memory stage holds a real instruction this cycle.
- mwreg  input  1  instruction writes a register.
- mm2reg  input  1  1 = write back load data, 0 = write back ALU result.
- mdestReg  input  5  destination register number.
- mr  input  32  ALU result; for loads this is the effective address.
- mdo  input  32  data-memory read word (word-aligned, little-endian byte lanes).
- mload_type  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 reserved, treated as LW.
- mflush  input  1  kill the instruction currently in the memory stage.
- wwreg  output  1  register-file write enable.
- wdestReg  output  5  register-file write address.
- wbData  output  32  register-file write data.
- wvalid  output  1  WB stage holds a retiring instruction.
- misalign_err  output  1  sticky misaligned-load flag.
- err_dest  output  5  destination register of the first misaligned load.
- retire_count  output  CNT_W  number of retired instructions.

## Operation
- Capture condition: cap = mvalid & ~mflush. When cap is 0, a bubble is loaded (wvalid=0, wwreg=0). wdestReg and wbData still load but are don't-care.
- Byte select uses b = mr[1:0]; halfword select uses h = mr[1].
- Load data by type:
  - LW: mdo.
  - LB: sign-extend mdo[8b+7:8b].
  - LBU: zero-extend mdo[8b+7:8b].
  - LH: sign-extend mdo[16h+15:16h].
  - LHU: zero-extend mdo[16h+15:16h].
- Misalignment (mis), evaluated only when mm2reg=1:
  - LW (and reserved types): mr[1:0] != 0.
  - LH/LHU: mr[0] = 1.
  - Byte loads are never misaligned.
- Next wbData = mm2reg ? load data : mr.
- Next wwreg = cap & mwreg & (mdestReg != 0) & ~(mm2reg & mis). Register 0 is never written.
- Next wvalid = cap. A misaligned load or an r0-destination write still retires (wvalid=1) with wwreg=0.
- misalign_err:
  - Sets on the rising edge capturing cap & mwreg & mm2reg & mis.
  - err_dest loads mdestReg only on the first set (while misalign_err=0).
  - Both hold until reset.
- retire_count increments by 1 on each rising edge where wvalid=1 (i.e. counts the instruction leaving WB) and wraps modulo 2^CNT_W.
- mflush takes priority over everything: a flushed instruction writes nothing, does not retire, and does not set misalign_err.

## Timing
- Reset (resetn=0, asynchronous): wwreg=0, wdestReg=0, wbData=0, wvalid=0, misalign_err=0, err_dest=0, retire_count=0.
- Outputs are registered and valid from the rising edge following capture. The register file writes on the next falling edge, giving a 1-cycle MEM→RF latency and a half-cycle write-before-read in decode.
- retire_count reflects an instruction one cycle after it appears on wvalid.
- Deassertion of resetn between edges: the first rising edge after deassertion captures normally.
- Reset asserted mid-operation: the pending write is dropped, because wwreg goes low asynchronously before the falling edge.
- Back-to-back writes to the same register: each cycle's write is independent; the last one wins.
- No input other than resetn affects the outputs combinationally.

## Test plan
- Reset, then ALU write: mvalid=1, mwreg=1, mm2reg=0, mdestReg=5, mr=0x12345678 → next cycle wwreg=1, wdestReg=5, wbData=0x12345678, wvalid=1; retire_count=1 one cycle later.
- Sub-word loads, each with mdo=0x80F17F01:
  - LB at mr=...2 → wbData=0xFFFFFFF1.
  - LBU at mr=...3 → 0x00000080.
  - LH at mr=...2 → 0xFFFF80F1.
  - LHU at mr=...0 → 0x00007F01.
- r0 protection: mdestReg=0, mwreg=1 → wwreg=0, wvalid=1, retire_count still increments.
- Misalignment:
  - LW at mr=0x1002, mdestReg=7 → wwreg=0, misalign_err=1, err_dest=7.
  - A later LH at mr=0x1001, mdestReg=9 → err_dest stays 7.
- Flush and bubble: mflush=1 with a valid write, then mvalid=0 → wwreg=0, wvalid=0, retire_count unchanged, misalign_err unchanged.
- Async reset mid-stream: resetn pulled low while wwreg=1, before the falling edge → wwreg=0 immediately; all outputs at reset values; RF target register unchanged.
